// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, 2-FF input synchronizer, one-entry valid/ready output buffer.
// Optional parity stage enabled with `define UART_RX_PARITY_EN (adds PARITY_ODD parameter and parity_err port).
module uart_rx_core #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // OVERSAMPLE must be even and >= 8 so the start-bit centre lands mid-bit.
    localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TCNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCNT_W  = $clog2(OVERSAMPLE);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DIV - 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_rxs_prev;
    logic [1:0]        r_fill;
    logic              r_armed;
    logic [TCNT_W-1:0] r_tcnt;
    logic [SCNT_W-1:0] r_scnt;
    logic [2:0]        r_bidx;
    logic [7:0]        r_shift;
    state_t            r_state;
    logic              r_brk;
    logic              r_commit;
    logic              r_busy;
    logic              r_frame_err;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_overrun;
`ifdef UART_RX_PARITY_EN
    logic              r_par_bit;
    logic              r_parity_err;
`endif

    logic w_rxs;
    logic w_fall;
    logic w_tick;
    logic w_xfer;

    assign w_rxs  = r_sync2;
    assign w_fall = r_armed & r_rxs_prev & ~w_rxs;
    assign w_tick = (r_tcnt == TCNT_LAST);
    assign w_xfer = r_valid & rx_ready;

    // Synchronizer plus arming: a line that is already low when reset releases must
    // first be seen high (with real synchronized data) before a falling edge counts.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
            r_fill     <= {r_fill[0], 1'b1};
            if (r_fill[1] && w_rxs) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Sample-tick divider; realigned to the start edge so bit centres track the frame.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state == S_IDLE && w_fall) begin
            r_tcnt <= '0;
        end else if (w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    // Frame FSM: start validation, data shift, optional parity, stop check.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_scnt      <= '0;
            r_bidx      <= '0;
            r_shift     <= '0;
            r_brk       <= 1'b0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_scnt  <= '0;
                        r_brk   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_scnt == SCNT_MID) begin
                            r_scnt <= '0;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                                r_bidx  <= '0;
                            end
                        end else begin
                            r_scnt <= r_scnt + SCNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_scnt == SCNT_LAST) begin
                            r_scnt  <= '0;
                            r_shift <= {w_rxs, r_shift[7:1]};
                            if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bidx <= r_bidx + 3'd1;
                            end
                        end else begin
                            r_scnt <= r_scnt + SCNT_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_scnt == SCNT_LAST) begin
                            r_scnt    <= '0;
                            r_par_bit <= w_rxs;
                            r_state   <= S_STOP;
                        end else begin
                            r_scnt <= r_scnt + SCNT_W'(1);
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (r_brk) begin
                        // Hold off after a bad stop until the line returns high.
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_brk   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_tick) begin
                        if (r_scnt == SCNT_LAST) begin
                            r_scnt <= '0;
                            if (w_rxs) begin
                                r_commit <= 1'b1;
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_brk       <= 1'b1;
                            end
                        end else begin
                            r_scnt <= r_scnt + SCNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer; a commit into a full, non-draining buffer is an overrun.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_commit & ((^r_shift) ^ r_par_bit ^ PARITY_ODD);
`endif
            if (r_commit) begin
                if (!r_valid || w_xfer) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: DIV=1, 16 clocks per bit; expected bytes queued at send time.
module tb_uart_rx_core;

    localparam int unsigned CLK_HZ   = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT_CLKS = 16;

    logic       mclk     = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    bit         par_flip = 1'b0;
`endif

    logic [7:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         n_xfer  = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;

    always #5 mclk = ~mclk;

    uart_rx_core #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endfunction

    // Monitor: inputs change 1ns after posedge, so negedge values decide the next edge.
    always @(negedge mclk) begin
        if (rst_n) begin
            if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) n_perr++;
`endif
            if (rx_valid && rx_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_xfer: got 0x%0h required no transfer", rx_data);
                end else begin
                    check("rx_data_xfer", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic send_head(input logic [7:0] d);
        rxd = 1'b0;
        clk(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            clk(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        clk(BIT_CLKS);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d);
        rxd = 1'b1;
        clk(BIT_CLKS);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        clk(3);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        clk(10);

        // Two back-to-back bytes, consumer always ready.
        rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55);
        send_frame(8'hA3);
        clk(10);
        check("t1_xfers", 32'(n_xfer), 32'd2);
        check("t1_frame_err", 32'(n_ferr), 32'd0);
        check("t1_overrun", 32'(overrun_err), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Short low glitch: false start.
        rxd = 1'b0;
        clk(5);
        check("t2_busy_glitch", 32'(busy), 32'd1);
        rxd = 1'b1;
        clk(40);
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_rx_valid", 32'(rx_valid), 32'd0);
        check("t2_xfers", 32'(n_xfer), 32'd2);
        check("t2_frame_err", 32'(n_ferr), 32'd0);

        // Stop bit low, line held low 40 clocks, then a good byte.
        send_head(8'h3C);
        rxd = 1'b0;
        clk(40);
        check("t3_busy_break", 32'(busy), 32'd1);
        check("t3_ferr_pulse", 32'(n_ferr), 32'd1);
        rxd = 1'b1;
        clk(20);
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_ferr_single", 32'(n_ferr), 32'd1);
        check("t3_rx_valid", 32'(rx_valid), 32'd0);
        check("t3_no_xfer", 32'(n_xfer), 32'd2);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        clk(10);
        check("t3_next_xfer", 32'(n_xfer), 32'd3);

        // Overrun: consumer stalled across three bytes.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11);
        check("t4_valid_b1", 32'(rx_valid), 32'd1);
        check("t4_data_b1", 32'(rx_data), 32'h11);
        check("t4_overrun_b1", 32'(overrun_err), 32'd0);
        send_frame(8'h22);
        check("t4_data_b2", 32'(rx_data), 32'h11);
        check("t4_overrun_b2", 32'(overrun_err), 32'd1);
        send_frame(8'h33);
        check("t4_data_b3", 32'(rx_data), 32'h11);
        clk(5);
        rx_ready = 1'b1;
        clk(5);
        check("t4_one_xfer", 32'(n_xfer), 32'd4);
        check("t4_valid_drained", 32'(rx_valid), 32'd0);
        check("t4_overrun_sticky", 32'(overrun_err), 32'd1);

        // Reset after bit 3 of 0xF0, released with line high.
        partial = 8'hF0;
        rxd = 1'b0;
        clk(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            clk(BIT_CLKS);
        end
        rxd = 1'b1;
        rst_n = 1'b0;
        clk(2);
        check("t5_rst_valid", 32'(rx_valid), 32'd0);
        check("t5_rst_data", 32'(rx_data), 32'd0);
        check("t5_rst_overrun", 32'(overrun_err), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        clk(20);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F);
        clk(10);
        check("t5_next_xfer", 32'(n_xfer), 32'd5);

        // Line already low at reset release is not a start.
        rxd = 1'b0;
        rst_n = 1'b0;
        clk(2);
        rst_n = 1'b1;
        clk(40);
        check("t6_busy_low_release", 32'(busy), 32'd0);
        rxd = 1'b1;
        clk(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A);
        clk(10);
        check("t6_next_xfer", 32'(n_xfer), 32'd6);
        check("t6_frame_err", 32'(n_ferr), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1; sending 0 must flag but still deliver.
        par_flip = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07);
        clk(10);
        check("t7_perr_bad", 32'(n_perr), 32'd1);
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07);
        clk(10);
        check("t7_perr_good", 32'(n_perr), 32'd1);
        check("t7_xfers", 32'(n_xfer), 32'd8);
`else
        check("t7_no_perr", 32'(n_perr), 32'd0);
`endif

        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
